// File: rtl/doorbell_target.sv
// SRIO target-side doorbell receiver: queues incoming HELLO DOORBELLs for the host
// and answers each with a RESPONSE (DONE, or ERROR when the queue is full).
module doorbell_target #(
    parameter int FIFO_AW = 4,
    parameter int CNT_W   = 16
) (
    input  logic               aclk,
    input  logic               aresetn,

    input  logic               s_axis_treq_tvalid,
    output logic               s_axis_treq_tready,
    input  logic [63:0]        s_axis_treq_tdata,
    input  logic [7:0]         s_axis_treq_tkeep,
    input  logic               s_axis_treq_tlast,
    input  logic [31:0]        s_axis_treq_tuser,

    output logic               m_axis_tresp_tvalid,
    input  logic               m_axis_tresp_tready,
    output logic [63:0]        m_axis_tresp_tdata,
    output logic [7:0]         m_axis_tresp_tkeep,
    output logic               m_axis_tresp_tlast,
    output logic [31:0]        m_axis_tresp_tuser,

    output logic               db_valid,
    input  logic               db_ready,
    output logic [15:0]        db_info,
    output logic [15:0]        db_src_id,
    output logic [FIFO_AW:0]   db_count,
    output logic               db_irq,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   ovf_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam int              DEPTH       = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [7:0]      TYPE_DB     = 8'hA0;
    localparam logic [3:0]      ST_DONE     = 4'h0;
    localparam logic [3:0]      ST_ERROR    = 4'h7;

    // Response priority is one above the request, capped at the top level.
    function automatic logic [1:0] resp_prio(input logic [1:0] prio);
        return (prio == 2'd3) ? 2'd3 : prio + 2'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t                 state_q, state_d;
    logic [63:0]            resp_tdata_q, resp_tdata_d;
    logic [31:0]            resp_tuser_q, resp_tuser_d;
    logic                   irq_q, irq_d;
    logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]       count_q, count_d;
    logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]       ovf_cnt_q, ovf_cnt_d;
    logic [31:0]            fifo_mem_q [DEPTH];

    logic                   treq_hs_s;
    logic                   is_db_s;
    logic                   full_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   fifo_nonempty_s;
    logic [31:0]            head_s;
    logic                   unused_s;

    assign treq_hs_s       = s_axis_treq_tvalid && (state_q != ST_RESP);
    assign is_db_s         = (s_axis_treq_tdata[55:48] == TYPE_DB);
    // Registered count only: a same-cycle pop never frees room for the push.
    assign full_s          = (count_q == FULL_COUNT);
    assign fifo_nonempty_s = (count_q != {(FIFO_AW+1){1'b0}});
    assign pop_s           = fifo_nonempty_s && db_ready;
    assign head_s          = fifo_mem_q[rd_ptr_q];
    assign unused_s        = ^{s_axis_treq_tkeep, s_axis_treq_tdata[47],
                               s_axis_treq_tdata[44:32], s_axis_treq_tdata[15:0]};

    // Next-state, response build and counter updates.
    always_comb begin
        state_d      = state_q;
        resp_tdata_d = resp_tdata_q;
        resp_tuser_d = resp_tuser_q;
        drop_cnt_d   = drop_cnt_q;
        ovf_cnt_d    = ovf_cnt_q;
        push_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (treq_hs_s) begin
                    if (is_db_s) begin
                        push_s       = !full_s;
                        ovf_cnt_d    = full_s ? sat_inc(ovf_cnt_q) : ovf_cnt_q;
                        resp_tdata_d = {s_axis_treq_tdata[63:56], 4'hD,
                                        full_s ? ST_ERROR : ST_DONE, 1'b0,
                                        resp_prio(s_axis_treq_tdata[46:45]), 1'b0, 44'h0};
                        resp_tuser_d = {s_axis_treq_tuser[15:0], s_axis_treq_tuser[31:16]};
                        state_d      = ST_RESP;
                    end else begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                        state_d    = s_axis_treq_tlast ? ST_IDLE : ST_DRAIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (treq_hs_s && s_axis_treq_tlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RESP: begin
                if (m_axis_tresp_tready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer/count bookkeeping and interrupt pulse.
    always_comb begin
        wr_ptr_d = push_s ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        irq_d    = push_s;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            resp_tdata_q <= 64'h0;
            resp_tuser_q <= 32'h0;
            irq_q        <= 1'b0;
            wr_ptr_q     <= {FIFO_AW{1'b0}};
            rd_ptr_q     <= {FIFO_AW{1'b0}};
            count_q      <= {(FIFO_AW+1){1'b0}};
            drop_cnt_q   <= {CNT_W{1'b0}};
            ovf_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            resp_tdata_q <= resp_tdata_d;
            resp_tuser_q <= resp_tuser_d;
            irq_q        <= irq_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_cnt_q   <= drop_cnt_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    // Doorbell storage; contents are only visible through the count, so no reset.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= {s_axis_treq_tuser[31:16], s_axis_treq_tdata[31:16]};
        end
    end

    assign s_axis_treq_tready  = (state_q != ST_RESP);
    assign m_axis_tresp_tvalid = (state_q == ST_RESP);
    assign m_axis_tresp_tdata  = resp_tdata_q;
    assign m_axis_tresp_tkeep  = 8'hFF;
    assign m_axis_tresp_tlast  = (state_q == ST_RESP);
    assign m_axis_tresp_tuser  = resp_tuser_q;

    assign db_valid  = fifo_nonempty_s;
    assign db_info   = fifo_nonempty_s ? head_s[15:0]  : 16'h0;
    assign db_src_id = fifo_nonempty_s ? head_s[31:16] : 16'h0;
    assign db_count  = count_q;
    assign db_irq    = irq_q;
    assign drop_cnt  = drop_cnt_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule
